// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store port with lane alignment, bus handshake, timeout and load extension
module lsu_mem_port #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            rsp_code,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OW = $clog2(NB);
    localparam int TC = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [OW-1:0]     off_q;
    logic              illegal;
    logic              misaligned;
    logic              tc;
    logic              msb;
    logic [OW-1:0]     off;
    logic [NB-1:0]     be_base;
    logic [DATA_W-1:0] repl;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lmask;
    logic [DATA_W-1:0] ext;

    assign req_ready = state == IDLE;

    // Request decode (alignment, lanes, replication) and load-data extraction from the latched access
    always_comb begin
        off        = req_addr[OW-1:0];
        illegal    = req_size == 2'd3 && DATA_W == 32;
        misaligned = (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'd0) ||
                     (req_size == 2'd3 && req_addr[2:0] != 3'd0);
        be_base    = (req_size == 2'd0) ? NB'(1) :
                     (req_size == 2'd1) ? NB'(3) :
                     (req_size == 2'd2) ? NB'(15) : {NB{1'b1}};
        repl       = (req_size == 2'd0) ? {NB{req_wdata[7:0]}} :
                     (req_size == 2'd1) ? {(NB/2){req_wdata[15:0]}} :
                     (req_size == 2'd2) ? {(NB/4){req_wdata[31:0]}} : req_wdata;
        shifted    = mem_rdata >> {off_q, 3'b000};
        lmask      = ~({DATA_W{1'b1}} << (32'd8 << size_q));
        msb        = (size_q == 2'd0) ? shifted[7] :
                     (size_q == 2'd1) ? shifted[15] :
                     (size_q == 2'd2) ? shifted[31] : shifted[DATA_W-1];
        ext        = (shifted & lmask) | ({DATA_W{sgn_q & msb}} & ~lmask);
        tc         = TIMEOUT != 0 && cnt == CW'(TC);
    end

    // Access FSM: accept/reject in IDLE, hold request until grant, wait for completion or timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_code  <= 2'd0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_code  <= 2'd0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        if (illegal || misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_code  <= illegal ? 2'd3 : 2'd1;
                        end else begin
                            state     <= REQ;
                            we_q      <= req_we;
                            sgn_q     <= req_signed;
                            size_q    <= req_size;
                            off_q     <= off;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:OW], OW'(0)};
                            mem_be    <= req_we ? be_base << off : '0;
                            mem_wdata <= repl;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (tc) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_code  <= 2'd2;
                    end else if (mem_gnt) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (mem_rvalid) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0 : ext;
                    end else if (tc) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_code  <= 2'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
